atm_keypad_entry: RTL



---
 rtl/atm_keypad_entry_if.sv | 23 ++
 rtl/atm_keypad_entry.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/atm_keypad_entry_if.sv
// atm_keypad_entry_if: keypad/auth inputs and login-request outputs of the ATM keypad front-end
interface atm_keypad_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        auth_done;
  logic        auth_ok;
  logic [11:0] accNumber;
  logic [3:0]  pin;
  logic        req_valid;
  logic        session;
  logic        exit;
  logic        locked;
  logic        entry_error;
  logic [2:0]  fail_count;
  modport master (
    output key_valid, key_code, auth_done, auth_ok,
    input  accNumber, pin, req_valid, session, exit, locked, entry_error, fail_count
  );
  modport slave (
    input  key_valid, key_code, auth_done, auth_ok,
    output accNumber, pin, req_valid, session, exit, locked, entry_error, fail_count
  );
endinterface

// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: keypad account/PIN collection, login request, session exit and failed-login lockout
module atm_keypad_entry #(
  parameter int ACC_DIGITS   = 4,
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 16,
  parameter int IDLE_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  atm_keypad_entry_if.slave kp
);
  localparam int DW = $clog2(ACC_DIGITS + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [DW-1:0] DMAX  = DW'(ACC_DIGITS);
  localparam logic [IW-1:0] ITOP  = IW'(IDLE_TIMEOUT - 1);
  localparam logic [LW-1:0] LLOAD = LW'(LOCK_CYCLES);
  localparam logic [LW-1:0] LONE  = LW'(1);
  localparam logic [2:0]    FMAX  = 3'(MAX_ATTEMPTS);
  localparam logic [3:0]    K_ENT = 4'hA, K_CLR = 4'hB, K_CAN = 4'hC;
  typedef enum logic [2:0] {S_ACC, S_PIN, S_REQ, S_SES, S_LCK} state_t;
  state_t        state_q, state_d;
  logic [11:0]   acc_q, acc_d;
  logic [3:0]    pin_q, pin_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [2:0]    fail_q, fail_d;
  logic          err_q, err_d, exit_q, exit_d;
  logic [16:0]   acc_nxt;
  logic [2:0]    fail_inc;
  logic          is_dig, is_flush, idle_run, clr;
  // wide enough that 4095*10+9 cannot wrap before the range check
  assign acc_nxt  = 17'(acc_q) * 17'd10 + 17'(kp.key_code);
  assign fail_inc = fail_q + 3'd1;
  assign is_dig   = kp.key_code <= 4'd9;
  assign is_flush = kp.key_code == K_CLR || kp.key_code == K_CAN;
  assign idle_run = (state_q == S_ACC && dig_q != '0) || state_q == S_PIN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      pin_q   <= '0;
      dig_q   <= '0;
      idle_q  <= '0;
      lock_q  <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pin_q   <= pin_d;
      dig_q   <= dig_d;
      idle_q  <= idle_d;
      lock_q  <= lock_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      exit_q  <= exit_d;
    end
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pin_d   = pin_q;
    dig_d   = dig_q;
    idle_d  = '0;
    lock_d  = lock_q;
    fail_d  = fail_q;
    err_d   = 1'b0;
    exit_d  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      S_ACC, S_PIN: begin
        if (kp.key_valid) begin
          if (is_flush) begin
            clr     = 1'b1;
            state_d = S_ACC;
          end else if (state_q == S_ACC && is_dig) begin
            if (dig_q >= DMAX || acc_nxt > 17'd4095) err_d = 1'b1;
            else begin
              acc_d = acc_nxt[11:0];
              dig_d = dig_q + 1'b1;
            end
          end else if (state_q == S_ACC && kp.key_code == K_ENT) begin
            if (dig_q == '0) err_d = 1'b1;
            else state_d = S_PIN;
          end else if (state_q == S_PIN && is_dig) begin
            pin_d   = kp.key_code;
            state_d = S_REQ;
          end else if (state_q == S_PIN && kp.key_code == K_ENT) err_d = 1'b1;
        end else if (idle_run) begin
          if (idle_q == ITOP) begin
            clr     = 1'b1;
            err_d   = 1'b1;
            state_d = S_ACC;
          end else idle_d = idle_q + 1'b1;
        end
      end
      // auth_done takes precedence; keys are never looked at while a request is pending
      S_REQ: if (kp.auth_done) begin
        if (kp.auth_ok) begin
          state_d = S_SES;
          fail_d  = '0;
        end else begin
          clr     = 1'b1;
          fail_d  = fail_inc;
          state_d = fail_inc == FMAX ? S_LCK : S_ACC;
          lock_d  = fail_inc == FMAX ? LLOAD : '0;
        end
      end
      S_SES: if (kp.key_valid && kp.key_code == K_CAN) begin
        clr     = 1'b1;
        exit_d  = 1'b1;
        state_d = S_ACC;
      end
      S_LCK: begin
        if (lock_q == LONE) begin
          state_d = S_ACC;
          fail_d  = '0;
          lock_d  = '0;
        end else lock_d = lock_q - 1'b1;
      end
      default: state_d = S_ACC;
    endcase
    if (clr) begin
      acc_d = '0;
      pin_d = '0;
      dig_d = '0;
    end
  end
  always_comb begin
    kp.accNumber   = acc_q;
    kp.pin         = pin_q;
    kp.req_valid   = state_q == S_REQ;
    kp.session     = state_q == S_SES;
    kp.locked      = state_q == S_LCK;
    kp.exit        = exit_q;
    kp.entry_error = err_q;
    kp.fail_count  = fail_q;
  end
endmodule
